uart_tx_ctrl: RTL and testbench

UART transmit sequencer for the AHB UART. It accepts one data word per valid/ready handshake and serialises it onto txd as a frame: start bit, data bits LSB first, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal baud divider. The parity bit is produced by an instance of the existing parity_generator, so PARITYSEL has the same meaning here: 0 = even, 1 = odd.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_ctrl_if.sv | 32 +++
 rtl/parity_generator.sv | 25 ++
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and line-level constants for the UART transmit
//             path (state encoding, idle/start levels, parity selection).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic PARITY_EVEN      = 1'b0;
    localparam logic PARITY_ODD       = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl_if
//  Purpose  : Valid/ready word handshake into the UART transmitter.
//  Signals  : tx_data  - word to transmit (DWIDTH bits)
//             tx_valid - tx_data is valid (producer -> transmitter)
//             tx_ready - transmitter can accept a word (transmitter -> producer)
//  Modports : master (word producer), slave (transmitter)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
    parameter int DWIDTH = 8
) ();

    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface : uart_tx_ctrl_if
`default_nettype wire

// File: rtl/parity_generator.sv
`default_nettype none
// ============================================================================
//  Module   : parity_generator
//  Purpose  : Combinational parity bit for a data word.
//  Ports    : data_i       in  DWIDTH  data word
//             parity_sel_i in  1       0 = even parity, 1 = odd parity
//             parity_o     out 1       bit that makes the total number of
//                                      ones (data + parity) even or odd
//  Revision : 1.0 - initial release
// ============================================================================
module parity_generator
    import uart_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  wire logic [DWIDTH-1:0] data_i,
    input  wire logic              parity_sel_i,
    output logic                   parity_o
);

    // Reduction XOR is the even-parity bit; odd parity is its inverse.
    assign parity_o = (^data_i) ^ (parity_sel_i == PARITY_ODD);

endmodule : parity_generator
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : UART transmit sequencer. Takes one word per valid/ready
//             handshake and serialises it as start, DWIDTH data bits (LSB
//             first), optional parity and one or two stop bits.
//  Ports    : HCLK      in  1      system clock (rising edge)
//             HRESETn   in  1      asynchronous active-low reset
//             tx_if     slave      tx_data / tx_valid / tx_ready handshake
//             baud_div  in  DIVW   each bit lasts baud_div+1 clocks
//             parity_en in  1      insert parity bit after data
//             PARITYSEL in  1      0 = even, 1 = odd parity
//             two_stop  in  1      0 = one stop bit, 1 = two stop bits
//             txd       out 1      serial line, idles high
//             busy      out 1      frame in progress
//             tx_done   out 1      one-cycle pulse in first idle cycle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DIVW   = 16
) (
    input  wire logic            HCLK,
    input  wire logic            HRESETn,
    uart_tx_ctrl_if.slave        tx_if,
    input  wire logic [DIVW-1:0] baud_div,
    input  wire logic            parity_en,
    input  wire logic            PARITYSEL,
    input  wire logic            two_stop,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int            BW         = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] C_LAST_BIT = BW'(DWIDTH - 1);

    uart_tx_state_t    state_q,    state_d;
    logic [DIVW-1:0]   cnt_q,      cnt_d;
    logic [BW-1:0]     bit_q,      bit_d;
    logic [DWIDTH-1:0] data_q,     data_d;
    logic [DIVW-1:0]   div_q,      div_d;
    logic              par_en_q,   par_en_d;
    logic              par_sel_q,  par_sel_d;
    logic              two_stop_q, two_stop_d;
    logic              txd_q,      txd_d;
    logic              done_q,     done_d;

    logic              parity_bit;
    logic              baud_tick;

    // Parity always comes from the shadowed word so mid-frame input
    // changes cannot leak into the frame in flight.
    parity_generator #(
        .DWIDTH (DWIDTH)
    ) u_parity (
        .data_i       (data_q),
        .parity_sel_i (par_sel_q),
        .parity_o     (parity_bit)
    );

    // Equality compare lets the full divisor range work without overflow care.
    assign baud_tick = (cnt_q == div_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_sel_d  = par_sel_q;
        two_stop_d = two_stop_q;
        done_d     = 1'b0;
        txd_d      = UART_IDLE_LEVEL;

        if (state_q == IDLE) begin
            if (tx_if.tx_valid) begin
                data_d     = tx_if.tx_data;
                div_d      = baud_div;
                par_en_d   = parity_en;
                par_sel_d  = PARITYSEL;
                two_stop_d = two_stop;
                cnt_d      = '0;
                bit_d      = '0;
                state_d    = START;
            end
        end else if (baud_tick) begin
            cnt_d = '0;
            case (state_q)
                START:  state_d = DATA;
                DATA: begin
                    if (bit_q == C_LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                PARITY: state_d = STOP1;
                STOP1: begin
                    if (two_stop_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                STOP2: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // txd is registered from the next state so the line changes on the
        // same edge that enters each bit period.
        case (state_d)
            START:   txd_d = UART_START_LEVEL;
            DATA:    txd_d = data_d[bit_d];
            PARITY:  txd_d = parity_bit;
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_sel_q  <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= UART_IDLE_LEVEL;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_sel_q  <= par_sel_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    assign tx_if.tx_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign txd            = txd_q;
    assign tx_done        = done_q;

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Self-checking bench for uart_tx_ctrl. Expected line activity
//             is built from the frame rules (bit list expanded by bit time).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int DW = 8;
    localparam int DV = 16;
    localparam int WATCH_LIMIT = 3000;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [DV-1:0] baud_div = '0;
    logic          parity_en = 1'b0;
    logic          PARITYSEL = 1'b0;
    logic          two_stop = 1'b0;
    logic          txd;
    logic          busy;
    logic          tx_done;

    always #5 HCLK = ~HCLK;

    uart_tx_ctrl_if #(.DWIDTH(DW)) tx_if ();

    uart_tx_ctrl #(
        .DWIDTH (DW),
        .DIVW   (DV)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .tx_if     (tx_if),
        .baud_div  (baud_div),
        .parity_en (parity_en),
        .PARITYSEL (PARITYSEL),
        .two_stop  (two_stop),
        .txd       (txd),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    int   checks   = 0;
    int   failures = 0;
    logic obs_q[$];
    logic exp_q[$];
    int   done_cyc;
    int   busy_low;
    logic done_busy, done_ready, done_txd;

    // Expected line level per clock for one frame.
    function automatic void model_frame(input logic [DW-1:0] d, input int div,
                                        input bit pe, input bit ps, input bit ts);
        logic bits[$];
        int   ones;
        ones = 0;
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) bits.push_back(ps ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[b])
            for (int r = 0; r <= div; r++) exp_q.push_back(bits[b]);
    endfunction

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return 9999;
        foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int frame_len(input int div, input bit pe, input bit ts);
        return (1 + DW + int'(pe) + 1 + int'(ts)) * (div + 1);
    endfunction

    task automatic start_frame(input logic [DW-1:0] d, input int div, input bit pe,
                               input bit ps, input bit ts, input bit hold);
        @(negedge HCLK);
        tx_if.tx_data  = d;
        baud_div       = DV'(div);
        parity_en      = pe;
        PARITYSEL      = ps;
        two_stop       = ts;
        tx_if.tx_valid = 1'b1;
        @(posedge HCLK);
        #1;
        if (!hold) tx_if.tx_valid = 1'b0;
    endtask

    // Records txd each cycle after a handshake edge until tx_done appears.
    task automatic watch_frame();
        obs_q.delete();
        done_cyc = -1;
        busy_low = 0;
        for (int c = 1; c <= WATCH_LIMIT; c++) begin
            @(negedge HCLK);
            if (tx_done === 1'b1) begin
                done_cyc   = c;
                done_busy  = busy;
                done_ready = tx_if.tx_ready;
                done_txd   = txd;
                break;
            end
            obs_q.push_back(txd);
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic test_reset();
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++;
        if ({txd, busy, tx_if.tx_ready, tx_done} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_state: txd/busy/ready/done=%b expected 1010",
                     {txd, busy, tx_if.tx_ready, tx_done});
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++;
        if ({txd, busy, tx_if.tx_ready, tx_done} !== 4'b1010) begin
            failures++;
            $display("FAIL idle_after_reset: txd/busy/ready/done=%b expected 1010",
                     {txd, busy, tx_if.tx_ready, tx_done});
        end
    endtask

    task automatic test_a5_even();
        int seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        start_frame(8'hA5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        watch_frame();
        exp_q.delete();
        foreach (seq[i]) repeat (4) exp_q.push_back(logic'(seq[i]));
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL a5_even_bits: first bad index %0d (got %0d samples, expected 44)",
                     first_diff(), obs_q.size());
        end
        checks++;
        if (done_cyc != 45) begin
            failures++;
            $display("FAIL a5_even_done: tx_done at cycle %0d expected 45", done_cyc);
        end
        checks++;
        if ({done_busy, done_ready, done_txd} !== 3'b011 || busy_low != 0) begin
            failures++;
            $display("FAIL a5_done_cycle_flags: busy/ready/txd=%b busy_low=%0d expected 011 and 0",
                     {done_busy, done_ready, done_txd}, busy_low);
        end
        @(negedge HCLK);
        checks++;
        if (tx_done !== 1'b0) begin
            failures++;
            $display("FAIL done_single_pulse: tx_done=%b expected 0", tx_done);
        end
    endtask

    task automatic test_parity();
        logic [DW-1:0] dv[3] = '{8'hA5, 8'h00, 8'h00};
        bit            sv[3] = '{1'b1, 1'b1, 1'b0};
        logic          pv[3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            start_frame(dv[k], 1, 1'b1, sv[k], 1'b0, 1'b0);
            watch_frame();
            checks++;
            if (obs_q.size() != 22 || obs_q[18] !== pv[k] || obs_q[19] !== pv[k]) begin
                failures++;
                $display("FAIL parity_bit[%0d]: data=%h sel=%0d got %b expected %b", k,
                         dv[k], sv[k], (obs_q.size() > 18) ? obs_q[18] : 1'bx, pv[k]);
            end
        end
    endtask

    task automatic test_two_stop();
        int seq[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        start_frame(8'h3C, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        watch_frame();
        exp_q.delete();
        foreach (seq[i]) exp_q.push_back(logic'(seq[i]));
        checks++;
        if (first_diff() != -1 || done_cyc != 12) begin
            failures++;
            $display("FAIL two_stop_frame: first bad index %0d done at %0d expected -1 and 12",
                     first_diff(), done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        tx_if.tx_data = 8'h02;
        watch_frame();
        model_frame(8'h01, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || done_cyc != frame_len(1, 1'b0, 1'b0) + 1) begin
            failures++;
            $display("FAIL b2b_first: first bad index %0d done at %0d expected -1 and %0d",
                     first_diff(), done_cyc, frame_len(1, 1'b0, 1'b0) + 1);
        end
        checks++;
        if ({done_busy, done_ready, done_txd} !== 3'b011) begin
            failures++;
            $display("FAIL b2b_gap: busy/ready/txd=%b expected 011",
                     {done_busy, done_ready, done_txd});
        end
        @(posedge HCLK);
        #1;
        tx_if.tx_valid = 1'b0;
        watch_frame();
        model_frame(8'h02, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || done_cyc != frame_len(1, 1'b0, 1'b0) + 1 || busy_low != 0) begin
            failures++;
            $display("FAIL b2b_second: first bad index %0d done at %0d busy_low=%0d expected -1, %0d, 0",
                     first_diff(), done_cyc, busy_low, frame_len(1, 1'b0, 1'b0) + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        done_seen = 0;
        start_frame(8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        // Cycles 13..16 carry data bit 2; abort inside it.
        repeat (14) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({txd, busy, tx_if.tx_ready, tx_done} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_mid_frame: txd/busy/ready/done=%b expected 1010",
                     {txd, busy, tx_if.tx_ready, tx_done});
        end
        repeat (3) begin
            @(negedge HCLK);
            if (tx_done !== 1'b0 || txd !== 1'b1) done_seen++;
        end
        HRESETn = 1'b1;
        repeat (2) begin
            @(negedge HCLK);
            if (tx_done !== 1'b0 || txd !== 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL reset_no_done: %0d bad cycles expected 0", done_seen);
        end
        start_frame(8'h55, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        watch_frame();
        model_frame(8'h55, 2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || done_cyc != frame_len(2, 1'b1, 1'b0) + 1) begin
            failures++;
            $display("FAIL post_reset_frame: first bad index %0d done at %0d expected -1 and %0d",
                     first_diff(), done_cyc, frame_len(2, 1'b1, 1'b0) + 1);
        end
    endtask

    task automatic test_mid_frame_change();
        start_frame(8'hA5, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        tx_if.tx_data = 8'h3C;
        baud_div      = 16'd0;
        PARITYSEL     = 1'b1;
        two_stop      = 1'b1;
        parity_en     = 1'b0;
        watch_frame();
        model_frame(8'hA5, 2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (first_diff() != -1 || done_cyc != frame_len(2, 1'b1, 1'b0) + 1) begin
            failures++;
            $display("FAIL mid_change_current: first bad index %0d done at %0d expected -1 and %0d",
                     first_diff(), done_cyc, frame_len(2, 1'b1, 1'b0) + 1);
        end
        start_frame(8'h3C, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        watch_frame();
        model_frame(8'h3C, 0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (first_diff() != -1 || done_cyc != frame_len(0, 1'b1, 1'b1) + 1) begin
            failures++;
            $display("FAIL mid_change_next: first bad index %0d done at %0d expected -1 and %0d",
                     first_diff(), done_cyc, frame_len(0, 1'b1, 1'b1) + 1);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        int            div;
        bit            pe, ps, ts;
        for (int n = 0; n < 10; n++) begin
            d   = DW'($urandom);
            div = int'($urandom_range(0, 5));
            pe  = 1'($urandom_range(0, 1));
            ps  = 1'($urandom_range(0, 1));
            ts  = 1'($urandom_range(0, 1));
            start_frame(d, div, pe, ps, ts, 1'b0);
            watch_frame();
            model_frame(d, div, pe, ps, ts);
            checks++;
            if (first_diff() != -1 || done_cyc != frame_len(div, pe, ts) + 1 || busy_low != 0) begin
                failures++;
                $display("FAIL random[%0d]: data=%h div=%0d pe=%0d ps=%0d ts=%0d bad index %0d done %0d expected -1 and %0d",
                         n, d, div, pe, ps, ts, first_diff(), done_cyc, frame_len(div, pe, ts) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5_even();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_mid_frame_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
